// File: rtl/node_mem_arbiter_if.sv
// Bus bundle between the three node-side requesters, the arbiter and the
// shared word memory. The arbiter sits on the slave side. The master side
// drives the requests and returns memory read data.
interface node_mem_arbiter_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);

  // Requester side. Requester i is packed at [i*WIDTH +: WIDTH].
  logic [2:0]              req;
  logic [2:0]              req_wr_en;
  logic [3*ADDR_WIDTH-1:0] req_addr;
  logic [3*WORD_WIDTH-1:0] req_wdata;
  logic [2:0]              gnt;
  logic [WORD_WIDTH-1:0]   rdata;

  // Shared memory side.
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_wr_en;
  logic [WORD_WIDTH-1:0]   mem_wdata;
  logic [WORD_WIDTH-1:0]   mem_rdata;

  // Status.
  logic                    busy;
  logic                    timeout_err;
  logic [1:0]              err_id;
  logic                    misalign_err;

  modport slave (
    input  req, req_wr_en, req_addr, req_wdata, mem_rdata,
    output gnt, rdata, mem_addr, mem_wr_en, mem_wdata,
           busy, timeout_err, err_id, misalign_err
  );

  modport master (
    output req, req_wr_en, req_addr, req_wdata, mem_rdata,
    input  gnt, rdata, mem_addr, mem_wr_en, mem_wdata,
           busy, timeout_err, err_id, misalign_err
  );

endinterface

// File: rtl/node_mem_arbiter.sv
// Three-way round-robin arbiter for a single-port node memory.
// Requesters: 0 = neighbor selection, 1 = Q update, 2 = packet handler.
// The arbiter registers a one-hot grant and then mirrors the owner onto the
// memory bus. When the owner lets go, it inserts one write-free turnaround
// cycle. A watchdog forces off any owner that holds the bus too long, and
// that requester stays ineligible until it drops its request once.
module node_mem_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clock,
  input  logic                 nrst,
  node_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // The watchdog is 8 bits wide, so the limit is taken modulo 256.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  // Round-robin successor: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  state_t     state_q,       state_d;
  logic [2:0] gnt_q,         gnt_d;
  logic [1:0] owner_q,       owner_d;        // index of the granted requester
  logic [1:0] rr_ptr_q,      rr_ptr_d;       // first index considered next time
  logic [7:0] wdog_q,        wdog_d;         // completed cycles in S_GRANT
  logic       timeout_err_q, timeout_err_d;
  logic [1:0] err_id_q,      err_id_d;
  logic [2:0] blocked_q,     blocked_d;      // forced-off requesters

  logic [2:0]            eligible;
  logic                  win_valid;
  logic [1:0]            win_idx;
  logic                  own_req;
  logic                  own_wr_en;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [WORD_WIDTH-1:0] own_wdata;

  // A forced-off requester can win again only after it drops its request.
  assign eligible = bus.req & ~blocked_q;

  // Round-robin pick: take the first eligible index at or after rr_ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    logic [1:0] cand;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Select the current owner's request fields from the packed buses.
  always_comb begin
    own_req   = 1'b0;
    own_wr_en = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (owner_q)
      2'd0: begin
        own_req   = bus.req[0];
        own_wr_en = bus.req_wr_en[0];
        own_addr  = bus.req_addr[0*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = bus.req_wdata[0*WORD_WIDTH +: WORD_WIDTH];
      end
      2'd1: begin
        own_req   = bus.req[1];
        own_wr_en = bus.req_wr_en[1];
        own_addr  = bus.req_addr[1*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = bus.req_wdata[1*WORD_WIDTH +: WORD_WIDTH];
      end
      2'd2: begin
        own_req   = bus.req[2];
        own_wr_en = bus.req_wr_en[2];
        own_addr  = bus.req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = bus.req_wdata[2*WORD_WIDTH +: WORD_WIDTH];
      end
      default: ;
    endcase
  end

  // Next-state logic: grant, release, watchdog and ineligibility tracking.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    timeout_err_d = 1'b0;
    err_id_d      = err_id_q;
    blocked_d     = blocked_q & bus.req;   // a low sample lifts the block

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d  = S_GRANT;
          gnt_d    = 3'b001 << win_idx;
          owner_d  = win_idx;
          rr_ptr_d = next_idx(win_idx);
          wdog_d   = 8'd0;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          state_d = S_RELEASE;
          gnt_d   = 3'b000;
        end else if (wdog_q + 8'd1 == TIMEOUT_CNT) begin
          state_d            = S_RELEASE;
          gnt_d              = 3'b000;
          timeout_err_d      = 1'b1;
          err_id_d           = owner_q;
          blocked_d[owner_q] = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!nrst) begin
      state_q       <= S_IDLE;
      gnt_q         <= 3'b000;
      owner_q       <= 2'd0;
      rr_ptr_q      <= 2'd0;
      wdog_q        <= 8'd0;
      timeout_err_q <= 1'b0;
      err_id_q      <= 2'd0;
      blocked_q     <= 3'b000;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      err_id_q      <= err_id_d;
      blocked_q     <= blocked_d;
    end
  end

  // Memory bus mirrors the owner only in S_GRANT. Addresses are word-aligned.
  always_comb begin
    bus.mem_addr     = '0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_wdata    = '0;
    bus.misalign_err = 1'b0;
    if (state_q == S_GRANT) begin
      bus.mem_addr     = {own_addr[ADDR_WIDTH-1:1], 1'b0};
      bus.mem_wr_en    = own_wr_en;
      bus.mem_wdata    = own_wdata;
      bus.misalign_err = own_addr[0];
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rdata       = bus.mem_rdata;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_id      = err_id_q;

endmodule

// File: tb/tb_node_mem_arbiter.sv
// Self-checking bench for node_mem_arbiter. It runs a directed vector table,
// then fairness and watchdog sequences, then randomized traffic. Every cycle
// is also compared against a transaction-level reference model.
module tb_node_mem_arbiter;

  localparam int WW = 16;
  localparam int AW = 11;
  localparam int TO = 255;

  logic clock = 1'b0;
  logic nrst  = 1'b0;

  node_mem_arbiter_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  node_mem_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bus ownership is tracked as "owner" (-1 = none) plus a turnaround flag.
  // The model also keeps the number of cycles the owner has held the bus.
  int       m_owner = -1;
  bit       m_turn  = 1'b0;
  int       m_held  = 0;
  int       m_ptr   = 0;
  int       m_err_id = 0;
  bit       m_err_pulse = 1'b0;
  bit [2:0] m_blk   = 3'b000;
  bit       chk_en  = 1'b0;
  logic [WW-1:0] rd_drv = '0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return bus.req_addr[i*AW +: AW];
  endfunction

  function automatic logic [WW-1:0] wdata_of(input int i);
    return bus.req_wdata[i*WW +: WW];
  endfunction

  task automatic model_step();
    logic [2:0] r;
    r = bus.req;
    if (!nrst) begin
      m_owner = -1; m_turn = 1'b0; m_held = 0; m_ptr = 0;
      m_err_id = 0; m_err_pulse = 1'b0; m_blk = 3'b000;
    end else begin
      m_err_pulse = 1'b0;
      if (m_turn) begin
        m_turn = 1'b0;
      end else if (m_owner >= 0) begin
        if (!r[m_owner]) begin
          m_owner = -1; m_turn = 1'b1;
        end else begin
          m_held++;
          if (m_held == TO) begin
            m_blk[m_owner] = 1'b1;
            m_err_id    = m_owner;
            m_err_pulse = 1'b1;
            m_owner = -1; m_turn = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          int c;
          c = (m_ptr + k) % 3;
          if (m_owner < 0 && r[c] && !m_blk[c]) begin
            m_owner = c; m_held = 0; m_ptr = (c + 1) % 3;
          end
        end
      end
      for (int i = 0; i < 3; i++) if (!r[i]) m_blk[i] = 1'b0;
    end
  endtask

  task automatic model_check();
    logic [2:0]    eg;
    logic [AW-1:0] a;
    logic [AW-1:0] ea;
    logic [WW-1:0] ed;
    logic          ew;
    logic          em;
    eg = '0; ea = '0; ed = '0; ew = 1'b0; em = 1'b0;
    if (m_owner >= 0) begin
      eg = 3'(1 << m_owner);
      a  = addr_of(m_owner);
      ea = {a[AW-1:1], 1'b0};
      ed = wdata_of(m_owner);
      ew = bus.req_wr_en[m_owner];
      em = a[0];
    end
    check("m_gnt",       32'(bus.gnt),          32'(eg));
    check("m_busy",      32'(bus.busy),         32'((m_owner >= 0) || m_turn));
    check("m_mem_wr_en", 32'(bus.mem_wr_en),    32'(ew));
    check("m_mem_addr",  32'(bus.mem_addr),     32'(ea));
    check("m_mem_wdata", 32'(bus.mem_wdata),    32'(ed));
    check("m_misalign",  32'(bus.misalign_err), 32'(em));
    check("m_timeout",   32'(bus.timeout_err),  32'(m_err_pulse));
    check("m_err_id",    32'(bus.err_id),       32'(m_err_id));
    check("m_rdata",     32'(bus.rdata),        32'(rd_drv));
  endtask

  task automatic to_neg();
    @(negedge clock);
    if (chk_en) model_check();
  endtask

  task automatic to_pos();
    @(posedge clock);
    model_step();
    #1;
    rd_drv = WW'($urandom);
    bus.mem_rdata = rd_drv;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  function automatic int onehot_idx(input logic [2:0] g);
    return g[2] ? 2 : (g[1] ? 1 : 0);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic          rst_n;
    logic [2:0]    req;
    logic [2:0]    wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a2;
    logic [WW-1:0] d0;
    logic [WW-1:0] d2;
    logic [2:0]    e_gnt;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wd;
    logic          e_mis;
    logic          e_busy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int            exp_order[4];
    int            order[$];
    int            runs[$];
    int            run;
    logic [2:0]    prevg;
    int            gcnt;
    int            tcnt;
    bit            released;
    bit            regrant;
    bit            got;

    bus.req = '0; bus.req_wr_en = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_rdata = rd_drv;
    nrst = 1'b0;
    to_pos();
    chk_en = 1'b1;
    tick();
    check("reset_gnt",     32'(bus.gnt),       32'h0);
    check("reset_busy",    32'(bus.busy),      32'h0);
    check("reset_err_id",  32'(bus.err_id),    32'h0);

    //            rst req     wr      a0      a2      d0        d2        gnt     wr    addr    wdata     mis   busy
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 11'h0,   11'h0,   16'h0,    16'h0,    3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'b001, 3'b001, 11'h2F8, 11'h0,   16'h0005, 16'h0,    3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b0};
    tbl[2]  = '{1'b1, 3'b001, 3'b001, 11'h2F8, 11'h0,   16'h0005, 16'h0,    3'b001, 1'b1, 11'h2F8, 16'h0005, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 3'b101, 3'b100, 11'h2F8, 11'h100, 16'h0005, 16'hBEEF, 3'b001, 1'b0, 11'h2F8, 16'h0005, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 3'b101, 3'b101, 11'h2F8, 11'h100, 16'h0005, 16'hBEEF, 3'b001, 1'b1, 11'h2F8, 16'h0005, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 3'b100, 3'b100, 11'h2F8, 11'h100, 16'h0005, 16'hBEEF, 3'b001, 1'b0, 11'h2F8, 16'h0005, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 3'b100, 3'b100, 11'h2F8, 11'h100, 16'h0005, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'b100, 3'b000, 11'h2F8, 11'h133, 16'h0005, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b0};
    tbl[8]  = '{1'b1, 3'b100, 3'b000, 11'h2F8, 11'h133, 16'h0005, 16'hBEEF, 3'b100, 1'b0, 11'h132, 16'hBEEF, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 3'b000, 3'b000, 11'h2F8, 11'h133, 16'h0005, 16'hBEEF, 3'b100, 1'b0, 11'h132, 16'hBEEF, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 3'b000, 3'b000, 11'h2F8, 11'h133, 16'h0005, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b1};
    tbl[11] = '{1'b1, 3'b001, 3'b001, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b0};
    tbl[12] = '{1'b1, 3'b001, 3'b001, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b001, 1'b1, 11'h040, 16'h1234, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'b001, 3'b001, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b001, 1'b1, 11'h040, 16'h1234, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 3'b011, 3'b001, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b0};
    tbl[15] = '{1'b1, 3'b011, 3'b001, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b001, 1'b1, 11'h040, 16'h1234, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 3'b000, 3'b001, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b001, 1'b1, 11'h040, 16'h1234, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 3'b000, 3'b000, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b1};
    tbl[18] = '{1'b1, 3'b000, 3'b000, 11'h040, 11'h133, 16'h1234, 16'hBEEF, 3'b000, 1'b0, 11'h0,   16'h0,    1'b0, 1'b0};

    nrst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      nrst          = tbl[i].rst_n;
      bus.req       = tbl[i].req;
      bus.req_wr_en = tbl[i].wr;
      bus.req_addr  = {tbl[i].a2, 11'h0, tbl[i].a0};
      bus.req_wdata = {tbl[i].d2, 16'h0, tbl[i].d0};
      to_neg();
      check($sformatf("t%0d_gnt", i),   32'(bus.gnt),          32'(tbl[i].e_gnt));
      check($sformatf("t%0d_wr", i),    32'(bus.mem_wr_en),    32'(tbl[i].e_wr));
      check($sformatf("t%0d_addr", i),  32'(bus.mem_addr),     32'(tbl[i].e_addr));
      check($sformatf("t%0d_wdata", i), 32'(bus.mem_wdata),    32'(tbl[i].e_wd));
      check($sformatf("t%0d_mis", i),   32'(bus.misalign_err), 32'(tbl[i].e_mis));
      check($sformatf("t%0d_busy", i),  32'(bus.busy),         32'(tbl[i].e_busy));
      to_pos();
    end
    nrst = 1'b1;

    // ---- watchdog: requester 1 holds for 300 cycles ----
    bus.req = 3'b000; bus.req_wr_en = 3'b010;
    repeat (3) tick();
    gcnt = 0; tcnt = 0; released = 1'b0; regrant = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.req = 3'b010;
      to_neg();
      if (bus.gnt == 3'b010) begin
        gcnt++;
        if (released) regrant = 1'b1;
      end else if (gcnt > 0) begin
        released = 1'b1;
      end
      if (bus.timeout_err) tcnt++;
      to_pos();
    end
    check("to_grant_cycles", 32'(gcnt),       32'd255);
    check("to_pulses",       32'(tcnt),       32'd1);
    check("to_err_id",       32'(bus.err_id), 32'd1);
    check("to_no_regrant",   32'(regrant),    32'd0);
    bus.req = 3'b000;
    tick();
    bus.req = 3'b010;
    got = 1'b0;
    for (int n = 0; n < 5 && !got; n++) begin
      to_neg();
      if (bus.gnt == 3'b010) got = 1'b1;
      to_pos();
    end
    check("to_regrant_after_drop", 32'(got), 32'd1);
    bus.req = 3'b000;
    repeat (3) tick();

    // ---- fairness: all three request, each drops after 3 grant cycles ----
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    exp_order = '{0, 1, 2, 0};
    prevg = 3'b000; run = 0;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      for (int i = 0; i < 3; i++) bus.req[i] = !(m_owner == i && m_held == 2);
      to_neg();
      if (bus.gnt != 3'b000) begin
        if (prevg == 3'b000) begin
          order.push_back(onehot_idx(bus.gnt));
          run = 1;
        end else begin
          run++;
        end
      end else if (prevg != 3'b000) begin
        runs.push_back(run);
      end
      prevg = bus.gnt;
      to_pos();
    end
    check("rr_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    for (int k = 0; k < 3 && k < runs.size(); k++)
      check($sformatf("rr_len%0d", k), 32'(runs[k]), 32'd3);
    bus.req = 3'b000;
    repeat (3) tick();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] flip;
      flip          = 3'($urandom) & 3'($urandom);
      bus.req       = bus.req ^ flip;
      bus.req_wr_en = 3'($urandom);
      bus.req_addr  = (3*AW)'({$urandom, $urandom});
      bus.req_wdata = (3*WW)'({$urandom, $urandom});
      nrst          = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_mem_arbiter.md
NODE_MEM_ARBITER -- requirements
Module: node_mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, memory address width (2048 bytes, 16-bit words at even addresses).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum grant length in cycles.
REQ-004 SHALL have port clock, input, 1, rising-edge clock.
REQ-005 SHALL have port nrst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port req, input, 3, per-requester access request (0 = neighbor selection, 1 = Q update, 2 = packet handler).
REQ-007 SHALL have port req_wr_en, input, 3, per-requester write enable.
REQ-008 SHALL have port req_addr, input, 3*ADDR_WIDTH, packed per-requester address (requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]).
REQ-009 SHALL have port req_wdata, input, 3*WORD_WIDTH, packed per-requester write data.
REQ-010 SHALL have port gnt, output, 3, one-hot grant.
REQ-011 SHALL have port rdata, output, WORD_WIDTH, memory read data broadcast to all requesters.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH, shared memory address.
REQ-013 SHALL have port mem_wr_en, output, 1, shared memory write enable.
REQ-014 SHALL have port mem_wdata, output, WORD_WIDTH, shared memory write data.
REQ-015 SHALL have port mem_rdata, input, WORD_WIDTH, shared memory read data.
REQ-016 SHALL have port busy, output, 1, high while in S_GRANT or S_RELEASE.
REQ-017 SHALL have port timeout_err, output, 1, one-cycle pulse on forced release.
REQ-018 SHALL have port err_id, output, 2, index of the last requester forced off; holds until the next timeout.
REQ-019 SHALL have port misalign_err, output, 1, high in any S_GRANT cycle where the granted address bit 0 is 1.

Function
REQ-020 SHALL implement states S_IDLE, S_GRANT and S_RELEASE.
REQ-021 In S_IDLE with any eligible req, SHALL register gnt for the winner and enter S_GRANT; gnt is high on the cycle after req is sampled (1-cycle latency).
REQ-022 SHALL select the winner round-robin: first eligible index at or after pointer rr_ptr, wrapping 2->0; on grant, rr_ptr SHALL become winner+1 mod 3.
REQ-023 In S_GRANT, mem_addr, mem_wr_en and mem_wdata SHALL combinationally mirror the granted requester, with mem_addr bit 0 forced to 0.
REQ-024 SHALL ignore req_wr_en of ungranted requesters.
REQ-025 Outside S_GRANT, mem_wr_en SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-026 rdata SHALL equal mem_rdata combinationally in all states.
REQ-027 When the granted req is sampled low in S_GRANT, SHALL clear gnt and enter S_RELEASE.
REQ-028 S_RELEASE SHALL last exactly one cycle (write-free turnaround), then go to S_IDLE.
REQ-029 A new req arriving during S_GRANT or S_RELEASE SHALL wait; no preemption.
REQ-030 An 8-bit watchdog SHALL count cycles in S_GRANT, clearing on entry.
REQ-031 If the count reaches TIMEOUT with req still high, SHALL enter S_RELEASE, pulse timeout_err and load err_id.
REQ-032 A requester forced off SHALL be ineligible until its req is sampled low once.
REQ-033 If the granted req drops and another req rises in the same cycle, SHALL still pass through S_RELEASE before granting.

Reset
REQ-034 On nrst low at a clock edge, SHALL set state S_IDLE, gnt 0, rr_ptr 0, watchdog 0, timeout_err 0, err_id 0, and clear all ineligibility masks; mem_wr_en SHALL be 0 from that edge.
REQ-035 Reset asserted mid-grant SHALL abort the access with no further write cycle.

Verification
REQ-036 Single request: req=3'b001 with addr 0x2F8, wr_en=1, wdata 0x0005 -> gnt=001 one cycle later; mem_addr=0x2F8, mem_wr_en=1, mem_wdata=0x0005.
REQ-037 All three requesters hold req for 3 cycles each, then drop -> grant order 0,1,2,0, with one S_RELEASE cycle (gnt=000) between grants.
REQ-038 Requester 1 holds req for 300 cycles -> forced release after 255 cycles in S_GRANT; timeout_err pulses once, err_id=1; requester 1 is not regranted until req drops.
REQ-039 Requester 2 drives wr_en=1 while requester 0 is granted -> mem_wr_en follows requester 0 only.
REQ-040 Granted addr 0x133 -> mem_addr=0x132, misalign_err=1.
REQ-041 nrst low while requester 0 is granted with wr_en=1 -> gnt=000 and mem_wr_en=0 at that edge; the first grant after reset goes to index 0.
